exc_pc: RTL and testbench

EXC_PC -- requirements
Module: exc_pc

---
 rtl/beta_pkg.sv | 15 +
 rtl/irq_prio.sv | 26 ++
 rtl/exc_pc.sv | 121 ++++++++++++
 tb/tb_exc_pc.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/beta_pkg.sv
// Shared definitions for the exception/interrupt PC unit: trap state encoding
// and cause-code constants.
package beta_pkg;

  typedef enum logic {
    NORMAL  = 1'b0,
    HANDLER = 1'b1
  } state_t;

  localparam int CAUSE_W = 4;

  // Cause 0 is a synchronous exception; irq channel k reports cause k+1.
  localparam logic [CAUSE_W-1:0] CAUSE_EXC = '0;

endpackage

// File: rtl/irq_prio.sv
// Lowest-index priority encoder over the unmasked pending interrupt requests.
module irq_prio
  import beta_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  output logic                 valid,
  output logic [CAUSE_W-1:0]   idx
);

  always_comb begin
    // NOTE: every combinational output gets a default before any branch,
    // otherwise paths that skip an assignment infer a latch.
    valid = 1'b0;
    idx   = '0;
    // Scan from the top down so the lowest asserted index is written last.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = CAUSE_W'(i);
      end
    end
  end

endmodule

// File: rtl/exc_pc.sv
// Program counter with synchronous exception and vectored, non-nesting
// interrupt handling; every output comes straight from a register.
module exc_pc
  import beta_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               NIRQ      = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = 'h0000_0000,
  parameter logic [WIDTH-1:0] VEC_BASE  = 'h0000_0080
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NIRQ-1:0]    irq,
  input  logic               exception,
  input  logic [WIDTH-1:0]   pcin,
  input  logic               stall,
  input  logic               eret,
  input  logic               mask_we,
  input  logic [NIRQ-1:0]    mask_wdata,
  output logic [WIDTH-1:0]   ia,
  output logic [WIDTH-1:0]   epc,
  output logic [CAUSE_W-1:0] cause,
  output logic               in_handler,
  output logic [NIRQ-1:0]    irq_mask,
  output logic [NIRQ-1:0]    pending,
  output logic               double_fault
);

  state_t               state, state_n;
  logic [WIDTH-1:0]     ia_n, epc_n;
  logic [CAUSE_W-1:0]   cause_n;
  logic                 double_fault_n;
  logic [NIRQ-1:0]      irq_q, pending_n, irq_mask_n, edges, clr;
  logic                 irq_valid;
  logic [CAUSE_W-1:0]   irq_idx;

  function automatic logic [WIDTH-1:0] vec_addr(input logic [CAUSE_W-1:0] c);
    return VEC_BASE + (WIDTH'(c) << 3);
  endfunction

  irq_prio #(.N(NIRQ)) u_prio (
    .req   (pending & ~irq_mask),
    .valid (irq_valid),
    .idx   (irq_idx)
  );

  assign edges      = irq & ~irq_q;
  assign in_handler = (state == HANDLER);

  always_comb begin
    state_n        = state;
    ia_n           = ia;
    epc_n          = epc;
    cause_n        = cause;
    double_fault_n = double_fault;
    clr            = '0;
    if (!stall) begin
      unique case (state)
        NORMAL: begin
          if (exception) begin
            epc_n   = ia;
            cause_n = CAUSE_EXC;
            ia_n    = vec_addr(CAUSE_EXC);
            state_n = HANDLER;
          end else if (irq_valid) begin
            epc_n   = pcin;
            cause_n = irq_idx + 4'd1;
            ia_n    = vec_addr(irq_idx + 4'd1);
            clr     = NIRQ'(1) << irq_idx;
            state_n = HANDLER;
          end else begin
            ia_n = pcin;
          end
        end
        HANDLER: begin
          // A fault inside the handler re-enters the exception vector but
          // keeps the original return address.
          if (exception) begin
            ia_n           = vec_addr(CAUSE_EXC);
            cause_n        = CAUSE_EXC;
            double_fault_n = 1'b1;
          end else if (eret) begin
            ia_n    = epc;
            state_n = NORMAL;
          end else begin
            ia_n = pcin;
          end
        end
        default: state_n = NORMAL;
      endcase
    end
    // A fresh edge on the channel being dispatched survives the clear.
    pending_n  = (pending & ~clr) | edges;
    irq_mask_n = mask_we ? mask_wdata : irq_mask;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= NORMAL;
      ia           <= RESET_VEC;
      epc          <= '0;
      cause        <= CAUSE_EXC;
      double_fault <= 1'b0;
      irq_mask     <= '1;
      pending      <= '0;
      irq_q        <= '0;
    end else begin
      state        <= state_n;
      ia           <= ia_n;
      epc          <= epc_n;
      cause        <= cause_n;
      double_fault <= double_fault_n;
      irq_mask     <= irq_mask_n;
      pending      <= pending_n;
      irq_q        <= irq;
    end
  end

endmodule

// File: tb/tb_exc_pc.sv
// Directed-vector bench for exc_pc with hand-computed expected values.
module tb_exc_pc;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  irq;
  logic        exception;
  logic [31:0] pcin;
  logic        stall;
  logic        eret;
  logic        mask_we;
  logic [3:0]  mask_wdata;
  logic [31:0] ia, epc;
  logic [3:0]  cause;
  logic        in_handler;
  logic [3:0]  irq_mask, pending;
  logic        double_fault;

  int total = 0;
  int bad   = 0;

  exc_pc dut (
    .clk          (clk),
    .reset        (reset),
    .irq          (irq),
    .exception    (exception),
    .pcin         (pcin),
    .stall        (stall),
    .eret         (eret),
    .mask_we      (mask_we),
    .mask_wdata   (mask_wdata),
    .ia           (ia),
    .epc          (epc),
    .cause        (cause),
    .in_handler   (in_handler),
    .irq_mask     (irq_mask),
    .pending      (pending),
    .double_fault (double_fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; irq = '0; exception = 1'b0; pcin = '0; stall = 1'b0;
    eret = 1'b0; mask_we = 1'b0; mask_wdata = '0;
    step(); step();
    check("rst_ia", ia, 32'h0);
    check("rst_epc", epc, 32'h0);
    check("rst_cause", 32'(cause), 32'h0);
    check("rst_inh", 32'(in_handler), 32'h0);
    check("rst_mask", 32'(irq_mask), 32'hF);
    check("rst_pend", 32'(pending), 32'h0);
    check("rst_df", 32'(double_fault), 32'h0);
    reset = 1'b0;

    // Sequential fetch
    pcin = 32'h4; step(); check("seq_ia4", ia, 32'h4);
    pcin = 32'h8; step(); check("seq_ia8", ia, 32'h8);
    pcin = 32'hC; step(); check("seq_iaC", ia, 32'hC);

    // Exception then eret
    pcin = 32'h10; step(); check("pre_exc_ia", ia, 32'h10);
    exception = 1'b1; pcin = 32'h14; step(); exception = 1'b0;
    check("exc_ia", ia, 32'h80);
    check("exc_epc", epc, 32'h10);
    check("exc_cause", 32'(cause), 32'h0);
    check("exc_inh", 32'(in_handler), 32'h1);
    eret = 1'b1; step(); eret = 1'b0;
    check("eret_ia", ia, 32'h10);
    check("eret_inh", 32'(in_handler), 32'h0);

    // Two simultaneous irqs, lowest wins, second taken after eret
    mask_we = 1'b1; mask_wdata = 4'h0; pcin = 32'h20; step(); mask_we = 1'b0;
    check("unmask", 32'(irq_mask), 32'h0);
    irq = 4'b0101; pcin = 32'h24; step();
    check("irq_pend", 32'(pending), 32'h5);
    check("irq_ia_pre", ia, 32'h24);
    step();
    check("irq0_ia", ia, 32'h88);
    check("irq0_cause", 32'(cause), 32'h1);
    check("irq0_epc", epc, 32'h24);
    check("irq0_pend", 32'(pending), 32'h4);
    pcin = 32'h8C; step(); check("hnd_ia", ia, 32'h8C);
    eret = 1'b1; step(); eret = 1'b0;
    check("eret2_ia", ia, 32'h24);
    check("eret2_pend", 32'(pending), 32'h4);
    pcin = 32'h28; step();
    check("irq2_ia", ia, 32'h98);
    check("irq2_cause", 32'(cause), 32'h3);
    check("irq2_pend", 32'(pending), 32'h0);
    eret = 1'b1; step(); eret = 1'b0;
    check("eret3_ia", ia, 32'h28);

    // Masked pending, then unmask
    irq = 4'b0000; mask_we = 1'b1; mask_wdata = 4'b0010; pcin = 32'h2C; step(); mask_we = 1'b0;
    check("mask2", 32'(irq_mask), 32'h2);
    irq = 4'b0010; pcin = 32'h30; step();
    check("msk_pend", 32'(pending), 32'h2);
    pcin = 32'h34; step();
    check("msk_ia", ia, 32'h34);
    check("msk_inh", 32'(in_handler), 32'h0);
    mask_we = 1'b1; mask_wdata = 4'h0; pcin = 32'h38; step(); mask_we = 1'b0;
    check("unmsk_ia", ia, 32'h38);
    pcin = 32'h3C; step();
    check("irq1_ia", ia, 32'h90);
    check("irq1_cause", 32'(cause), 32'h2);
    eret = 1'b1; step(); eret = 1'b0;
    check("eret4_ia", ia, 32'h3C);

    // Double fault: exception and eret together in HANDLER
    exception = 1'b1; pcin = 32'h40; step();
    check("exc2_epc", epc, 32'h3C);
    eret = 1'b1; step(); eret = 1'b0; exception = 1'b0;
    check("df_ia", ia, 32'h80);
    check("df_flag", 32'(double_fault), 32'h1);
    check("df_epc", epc, 32'h3C);
    check("df_inh", 32'(in_handler), 32'h1);
    eret = 1'b1; step(); eret = 1'b0;
    check("df_eret_ia", ia, 32'h3C);
    check("df_sticky", 32'(double_fault), 32'h1);

    // Stall holds PC while edges still latch
    irq = 4'b0000; pcin = 32'h40; step();
    check("pre_stall_ia", ia, 32'h40);
    stall = 1'b1; irq = 4'b0001; pcin = 32'h50;
    step(); step(); step();
    check("stall_ia", ia, 32'h40);
    check("stall_pend", 32'(pending), 32'h1);
    check("stall_inh", 32'(in_handler), 32'h0);
    stall = 1'b0; pcin = 32'h44; step();
    check("unstall_ia", ia, 32'h88);
    check("unstall_cause", 32'(cause), 32'h1);
    check("unstall_epc", epc, 32'h44);

    // Reset mid-handler with a pending edge
    irq = 4'b0011; pcin = 32'h8C; step();
    check("mid_pend", 32'(pending), 32'h2);
    #2 reset = 1'b1; #1;
    check("arst_ia", ia, 32'h0);
    check("arst_epc", epc, 32'h0);
    check("arst_pend", 32'(pending), 32'h0);
    check("arst_inh", 32'(in_handler), 32'h0);
    check("arst_df", 32'(double_fault), 32'h0);
    check("arst_mask", 32'(irq_mask), 32'hF);
    irq = 4'b0000; step(); reset = 1'b0;
    pcin = 32'h4; step();
    check("post_rst_ia", ia, 32'h4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
